pc_sequencer: RTL
=================

Name: pc_sequencer

Overview:
- Fetch-stage controller that drives the PC register's load enable (`pc_we`) and next-PC value (`next_pc`) each cycle.
- Arbitrates among five next-PC sources: exception vector, jump, branch, sequential PC+4 and boot vector.
- Sequences I-cache misses, decode stalls and halt/resume.
- Sits between the I-cache and hazard unit and the PC register; its outputs feed the register's `hit` and `nextPC` inputs directly.

Parameters:
- RESET_VECTOR, 32'h0000_0000, PC loaded on the first cycle after reset.
- EXC_VECTOR, 32'h0000_0080, PC loaded on exception.
- SIZE, 32, PC width.

Ports:
- clk  in  1  system clock; all state updates on posedge
- rst_n  in  1  asynchronous active-low reset
- cur_pc  in  SIZE  current PC register output
- icache_hit  in  1  instruction at cur_pc available this cycle
- stall  in  1  decode/hazard stall; PC must hold
- branch_taken  in  1  taken branch resolved this cycle
- branch_target  in  SIZE  branch target
- jump_valid  in  1  jump resolved this cycle
- jump_target  in  SIZE  jump target
- exc_valid  in  1  exception request
- halt_req  in  1  request to halt fetch
- resume  in  1  leave HALT
- pc_we  out  1  PC register load enable
- next_pc  out  SIZE  value to load
- fetch_state  out  2  00 BOOT, 01 RUN, 10 MISS, 11 HALT
- redirect_pending  out  1  latched redirect waiting to be applied

Behaviour:
- Reset (async, rst_n=0):
  - state=BOOT, pending=0, pending_target=0.
  - Outputs during reset: pc_we=0, next_pc=RESET_VECTOR, fetch_state=00, redirect_pending=0.
- BOOT: pc_we=1, next_pc=RESET_VECTOR for exactly one cycle, then RUN. All inputs are ignored in BOOT.
- Output timing: outputs are Mealy (combinational from state, pending and inputs) and are valid before the negedge on which the PC register samples them. Redirect latency is 0 cycles.
- Redirect priority, highest first: exc_valid > jump_valid > branch_taken > pending > sequential (cur_pc+4, mod 2^SIZE, wraps FFFF_FFFC->0000_0000).
- exc_valid in RUN, MISS or HALT:
  - pc_we=1, next_pc=EXC_VECTOR, regardless of stall or icache_hit.
  - pending is cleared; next state is RUN.
- RUN, no exception:
  - halt_req=1: pc_we=0, next state HALT. Any redirect in the same cycle is latched into pending.
  - Redirect present with icache_hit=1 and stall=0: pc_we=1, next_pc=target, pending unchanged (stays 0).
  - Redirect present with icache_hit=0 or stall=1: pc_we=0, target latched into pending (jump wins over branch).
  - No redirect, icache_hit=1, stall=0: pc_we=1, next_pc = pending ? pending_target : cur_pc+4. pending is cleared when consumed.
  - icache_hit=0: pc_we=0, next state MISS.
- MISS:
  - While icache_hit=0: pc_we=0. New redirects are latched; a later redirect overwrites an earlier one.
  - icache_hit=1: next state RUN. In the same cycle the RUN rules apply (load if stall=0).
- HALT:
  - pc_we=0. pending and redirect latching still operate.
  - resume=1: next state RUN, pc_we=0 that cycle.
  - halt_req and resume both high: remain in HALT.
- Stall and redirect together: the redirect is never dropped; it is applied on the first cycle with icache_hit=1 and stall=0.
- Reset asserted mid-MISS or with pending=1: everything returns to reset values immediately; the pending target is discarded.

Optional Feature:
- Macro: PC_SEQ_PERF_EN.
- Defined:
  - Adds outputs perf_miss_cycles[31:0] (cycles spent in MISS) and perf_redirects[31:0] (applied redirects, including exceptions).
  - Both counters saturate at FFFF_FFFF and reset to 0.
- Undefined: counters and ports are absent; behaviour is otherwise identical.

Test Plan:
- Boot: release rst_n, icache_hit=1 -> cycle 1 pc_we=1 next_pc=0000_0000; cur_pc=0 next cycle gives next_pc=0000_0004, pc_we=1.
- Miss then branch: cur_pc=0000_0010; icache_hit=0 for 3 cycles, branch_taken=1 target 0000_0200 on miss cycle 2 -> pc_we=0 for 3 cycles, redirect_pending=1; hit returns -> next_pc=0000_0200, pc_we=1, pending=0.
- Priority: exc_valid, jump_valid (0000_0400) and branch_taken all high with stall=1 -> pc_we=1, next_pc=0000_0080, pending=0.
- Stall with jump: stall=1 two cycles with jump_valid to 0000_0300 on the first -> pc_we=0 both cycles; stall drops -> next_pc=0000_0300.
- Wrap: cur_pc=FFFF_FFFC, hit=1 -> next_pc=0000_0000.
- Halt/reset: halt_req in RUN -> fetch_state=11, pc_we=0; assert rst_n=0 while pending=1 -> fetch_state=00 immediately, pending=0; with PC_SEQ_PERF_EN, counters read 0.

Source files
------------

// File: rtl/pc_sequencer_if.sv
// Fetch-sequencer bus: PC feedback, I-cache/hazard status, redirect requests in; PC load controls out.
// Latency: none, this is a bundle of wires.
// Backpressure: none of its own; icache_hit and stall are the hold conditions.
interface pc_sequencer_if #(
    parameter int SIZE = 32
);
    logic [SIZE-1:0] cur_pc;
    logic            icache_hit;
    logic            stall;
    logic            branch_taken;
    logic [SIZE-1:0] branch_target;
    logic            jump_valid;
    logic [SIZE-1:0] jump_target;
    logic            exc_valid;
    logic            halt_req;
    logic            resume;
    logic            pc_we;
    logic [SIZE-1:0] next_pc;
    logic [1:0]      fetch_state;
    logic            redirect_pending;

    // Side that drives the fetch status and redirects (pipeline / testbench).
    modport master (
        output cur_pc, icache_hit, stall, branch_taken, branch_target,
               jump_valid, jump_target, exc_valid, halt_req, resume,
        input  pc_we, next_pc, fetch_state, redirect_pending
    );

    // Side that is the sequencer itself.
    modport slave (
        input  cur_pc, icache_hit, stall, branch_taken, branch_target,
               jump_valid, jump_target, exc_valid, halt_req, resume,
        output pc_we, next_pc, fetch_state, redirect_pending
    );
endinterface

// File: rtl/pc_sequencer.sv
// Fetch-stage PC sequencer: picks the next PC (exception > jump > branch > pending > PC+4) and drives pc_we.
// Latency: 0 cycles; outputs are Mealy, combinational from state, pending and inputs.
// Backpressure: holds the PC on a miss, stall or halt, and latches a redirect until it can be applied.
// Optional perf counters are enabled by defining PC_SEQ_PERF_EN.
module pc_sequencer #(
    parameter int              SIZE         = 32,
    parameter logic [SIZE-1:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [SIZE-1:0] EXC_VECTOR   = 32'h0000_0080
) (
    input  logic              clk,
    input  logic              rst_n,
    pc_sequencer_if.slave     bus
`ifdef PC_SEQ_PERF_EN
    ,
    output logic [31:0]       perf_miss_cycles,
    output logic [31:0]       perf_redirects
`endif
);

    typedef enum logic [1:0] {
        BOOT = 2'b00,
        RUN  = 2'b01,
        MISS = 2'b10,
        HALT = 2'b11
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic            pending;
    logic            pending_nxt;
    logic [SIZE-1:0] pending_target;
    logic [SIZE-1:0] pending_target_nxt;
    logic            load;
    logic [SIZE-1:0] load_pc;
    logic            applied;

    logic            redir;
    logic [SIZE-1:0] redir_target;
    logic [SIZE-1:0] seq_pc;

    // Jump outranks branch whenever both resolve in the same cycle.
    assign redir        = bus.jump_valid | bus.branch_taken;
    assign redir_target = bus.jump_valid ? bus.jump_target : bus.branch_target;
    assign seq_pc       = bus.cur_pc + SIZE'(4);

    // State, pending flag and pending target register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= BOOT;
            pending        <= 1'b0;
            pending_target <= '0;
        end else begin
            state          <= state_nxt;
            pending        <= pending_nxt;
            pending_target <= pending_target_nxt;
        end
    end

    // Next-state, pending update and PC load selection.
    always_comb begin
        state_nxt          = state;
        pending_nxt        = pending;
        pending_target_nxt = pending_target;
        load               = 1'b0;
        load_pc            = bus.cur_pc;
        applied            = 1'b0;

        unique case (state)
            BOOT: begin
                // Inputs are ignored: the very first load is always the boot vector.
                load      = 1'b1;
                load_pc   = RESET_VECTOR;
                state_nxt = RUN;
            end
            default: begin
                if (bus.exc_valid) begin
                    load        = 1'b1;
                    load_pc     = EXC_VECTOR;
                    pending_nxt = 1'b0;
                    applied     = 1'b1;
                    state_nxt   = RUN;
                end else if (state == HALT || (state == MISS && !bus.icache_hit)) begin
                    // Not fetching: keep collecting redirects, newest wins.
                    if (redir) begin
                        pending_nxt        = 1'b1;
                        pending_target_nxt = redir_target;
                    end
                    if (state == HALT && bus.resume && !bus.halt_req) begin
                        state_nxt = RUN;
                    end
                end else begin
                    // RUN, or MISS on the cycle the line arrives: ordinary fetch rules.
                    state_nxt = RUN;
                    if (bus.halt_req || !bus.icache_hit || bus.stall) begin
                        if (redir) begin
                            pending_nxt        = 1'b1;
                            pending_target_nxt = redir_target;
                        end
                        if (bus.halt_req) begin
                            state_nxt = HALT;
                        end else if (!bus.icache_hit) begin
                            state_nxt = MISS;
                        end
                    end else if (redir) begin
                        // A fresh redirect supersedes any older latched one.
                        load        = 1'b1;
                        load_pc     = redir_target;
                        pending_nxt = 1'b0;
                        applied     = 1'b1;
                    end else if (pending) begin
                        load        = 1'b1;
                        load_pc     = pending_target;
                        pending_nxt = 1'b0;
                        applied     = 1'b1;
                    end else begin
                        load    = 1'b1;
                        load_pc = seq_pc;
                    end
                end
            end
        endcase
    end

    // While reset is held the BOOT load must not reach the PC register.
    assign bus.pc_we            = load & rst_n;
    assign bus.next_pc          = rst_n ? load_pc : RESET_VECTOR;
    assign bus.fetch_state      = state;
    assign bus.redirect_pending = pending;

`ifdef PC_SEQ_PERF_EN
    // Saturating counters: cycles spent in MISS and redirects actually loaded.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_miss_cycles <= '0;
            perf_redirects   <= '0;
        end else begin
            if (state == MISS && perf_miss_cycles != 32'hFFFF_FFFF) begin
                perf_miss_cycles <= perf_miss_cycles + 32'd1;
            end
            if (applied && perf_redirects != 32'hFFFF_FFFF) begin
                perf_redirects <= perf_redirects + 32'd1;
            end
        end
    end
`endif

endmodule
